// File: rtl/spk_schmitt_trigger_pkg.sv
// Shared constants and types for the spike generator and its neighbours in the spike processor.
// Holds the default potential width and thresholds, the layer-select codes, and the hysteresis rule.
package spk_schmitt_trigger_pkg;

    localparam int POT_WIDTH  = 8;
    localparam int V_HIGH_DEF = 64;
    localparam int V_LOW_DEF  = 0;

    typedef enum logic [1:0] {
        INPUT_LAYER  = 2'd0,
        HIDDEN_LAYER = 2'd1,
        OUTPUT_LAYER = 2'd2
    } layer_e;

    typedef struct packed {
        logic spk;
        logic spkblty;
    } spk_out_t;

    // A refractory neuron never fires, even above V_HIGH; it only re-arms.
    function automatic spk_out_t schmitt_next(input logic armed,
                                              input logic ge_high,
                                              input logic le_low);
        spk_out_t r;
        r.spk     = 1'b0;
        r.spkblty = 1'b0;
        if (armed) begin
            r.spk     = ge_high;
            r.spkblty = ~ge_high;
        end else begin
            r.spkblty = le_low;
        end
        return r;
    endfunction

endpackage

// File: rtl/spk_schmitt_trigger_if.sv
// Neuron-side bundle: potential and arm state in, spike and arm write-back out.
interface spk_schmitt_trigger_if #(
    parameter int WIDTH = 8
);
    logic signed [WIDTH-1:0] potential;
    logic                    spkblty_in;
    logic                    spk;
    logic                    spkblty_out;

    modport master (
        output potential,
        output spkblty_in,
        input  spk,
        input  spkblty_out
    );

    modport slave (
        input  potential,
        input  spkblty_in,
        output spk,
        output spkblty_out
    );
endinterface

// File: rtl/spk_schmitt_trigger_thresh_cmp.sv
// Signed threshold comparator; thresholds are truncated/sign-extended to WIDTH bits.
module spk_schmitt_trigger_thresh_cmp #(
    parameter int WIDTH  = 8,
    parameter int V_HIGH = 64,
    parameter int V_LOW  = 0
) (
    input  logic signed [WIDTH-1:0] value_i,
    output logic                    ge_high_o,
    output logic                    le_low_o
);
    localparam logic signed [WIDTH-1:0] VH_T = WIDTH'(V_HIGH);
    localparam logic signed [WIDTH-1:0] VL_T = WIDTH'(V_LOW);

    assign ge_high_o = (value_i >= VH_T);
    assign le_low_o  = (value_i <= VL_T);
endmodule

// File: rtl/spk_schmitt_trigger.sv
// Per-neuron Schmitt-trigger spike generator; arm state lives outside and is read/written each cycle.
// Outputs are registered, so they reflect the inputs sampled at the previous rising edge.
module spk_schmitt_trigger
    import spk_schmitt_trigger_pkg::*;
#(
    parameter int WIDTH  = POT_WIDTH,
    parameter int V_HIGH = V_HIGH_DEF,
    parameter int V_LOW  = V_LOW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    spk_schmitt_trigger_if.slave bus
);

    generate
        if (V_LOW >= V_HIGH) begin : g_bad_thresh
            $fatal(1, "spk_schmitt_trigger: V_LOW (%0d) must be below V_HIGH (%0d)", V_LOW, V_HIGH);
        end
        if (WIDTH < 2) begin : g_bad_width
            $fatal(1, "spk_schmitt_trigger: WIDTH (%0d) must be at least 2", WIDTH);
        end
    endgenerate

    logic     ge_high;
    logic     le_low;
    spk_out_t nxt;
    logic     spk_d, spk_q;
    logic     spkblty_d, spkblty_q;

    spk_schmitt_trigger_thresh_cmp #(
        .WIDTH  (WIDTH),
        .V_HIGH (V_HIGH),
        .V_LOW  (V_LOW)
    ) u_cmp (
        .value_i   (bus.potential),
        .ge_high_o (ge_high),
        .le_low_o  (le_low)
    );

    always_comb begin
        nxt       = schmitt_next(bus.spkblty_in, ge_high, le_low);
        spk_d     = nxt.spk;
        spkblty_d = nxt.spkblty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spk_q     <= 1'b0;
            spkblty_q <= 1'b1;
        end else begin
            spk_q     <= spk_d;
            spkblty_q <= spkblty_d;
        end
    end

    assign bus.spk         = spk_q;
    assign bus.spkblty_out = spkblty_q;

endmodule

// File: tb/tb_spk_schmitt_trigger.sv
// Directed scoreboard bench for the Schmitt-trigger spike generator.
module tb_spk_schmitt_trigger;

    logic clk;
    logic reset;
    int   checks;
    int   passed;
    logic [1:0] exp_q[$];
    string      tag_q[$];

    spk_schmitt_trigger_if #(.WIDTH(8)) bus ();

    spk_schmitt_trigger #(
        .WIDTH  (8),
        .V_HIGH (64),
        .V_LOW  (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference hysteresis rule: {spk, next arm}.
    function automatic logic [1:0] ref_next(input logic signed [7:0] p, input logic armed);
        if (armed) return (p >= 8'sd64) ? 2'b10 : 2'b01;
        return (p <= 8'sd0) ? 2'b01 : 2'b00;
    endfunction

    task automatic check_out();
        logic [1:0] e;
        string      t;
        checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty got none exp entry");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (bus.spk === e[1]) passed++;
        else $error("FAIL %s spk got %b exp %b", t, bus.spk, e[1]);
        checks++;
        assert (bus.spkblty_out === e[0]) passed++;
        else $error("FAIL %s spkblty_out got %b exp %b", t, bus.spkblty_out, e[0]);
    endtask

    task automatic step(input logic r, input logic [7:0] p, input logic a,
                        input logic e_spk, input logic e_arm, input string tag);
        reset          = r;
        bus.potential  = p;
        bus.spkblty_in = a;
        exp_q.push_back({e_spk, e_arm});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [7:0] ramp [8];
        logic       spk_tab [8];
        logic [1:0] nxt;
        logic       m_arm;

        ramp    = '{8'd0, 8'd32, 8'd64, 8'd96, 8'd64, 8'd32, 8'd0, 8'd64};
        spk_tab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks = 0;
        passed = 0;
        reset = 1'b1;
        bus.potential  = 8'd0;
        bus.spkblty_in = 1'b0;

        step(1'b1, 8'd100, 1'b1, 1'b0, 1'b1, "rst_cyc0");
        step(1'b1, 8'd100, 1'b1, 1'b0, 1'b1, "rst_cyc1");
        step(1'b0, 8'd100, 1'b1, 1'b1, 1'b0, "rst_release");

        step(1'b0, 8'd63,  1'b1, 1'b0, 1'b1, "armed_p63");
        step(1'b0, 8'd64,  1'b1, 1'b1, 1'b0, "armed_p64");
        step(1'b0, 8'd127, 1'b1, 1'b1, 1'b0, "armed_p127");
        step(1'b0, 8'd127, 1'b1, 1'b1, 1'b0, "armed_p127_hold");

        step(1'b0, 8'd100, 1'b0, 1'b0, 1'b0, "refr_p100");
        step(1'b0, 8'd1,   1'b0, 1'b0, 1'b0, "refr_p1");
        step(1'b0, 8'd0,   1'b0, 1'b0, 1'b1, "refr_p0");
        step(1'b0, 8'h80,  1'b0, 1'b0, 1'b1, "refr_pm128");
        step(1'b0, 8'h80,  1'b1, 1'b0, 1'b1, "armed_pm128");
        step(1'b0, 8'hC0,  1'b1, 1'b0, 1'b1, "armed_pm64_signed");

        step(1'b0, 8'd100, 1'b1, 1'b1, 1'b0, "pre_mid_rst");
        step(1'b1, 8'd100, 1'b0, 1'b0, 1'b1, "mid_rst");
        step(1'b0, 8'd100, 1'b0, 1'b0, 1'b0, "post_mid_rst");

        step(1'b1, 8'd0, 1'b1, 1'b0, 1'b1, "cl_rst");
        m_arm = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nxt   = ref_next(ramp[i], m_arm);
            step(1'b0, ramp[i], bus.spkblty_out, spk_tab[i], nxt[0],
                 $sformatf("loop_%0d_p%0d", i, ramp[i]));
            m_arm = nxt[0];
        end

        checks++;
        assert (exp_q.size() == 0) passed++;
        else $error("FAIL scoreboard_drain got %0d exp 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/spk_schmitt_trigger.md
Name: spk_schmitt_trigger

Overview:
- Per-neuron spike generator with hysteresis (Schmitt trigger) on an 8-bit membrane potential.
- Emits a spike when the potential reaches the high threshold while the neuron is armed ("spikeable"), then disarms.
- Re-arms only after the potential falls to or below the low threshold.
- Arm state (spikeability) is held externally, read in via spkblty_in and written back from spkblty_out; replicated 16x in the spike processor's hidden-layer path.

Parameters:
- WIDTH, 8, potential bit width.
- V_HIGH, 64, signed spike threshold; spike when potential >= V_HIGH.
- V_LOW, 0, signed re-arm threshold; re-arm when potential <= V_LOW. Must satisfy V_LOW < V_HIGH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- potential  input  WIDTH  membrane potential, two's-complement signed.
- spkblty_in  input  1  current spikeability (1 = armed, 0 = refractory).
- spk  output  1  spike flag, registered.
- spkblty_out  output  1  next spikeability for write-back, registered.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on rising edge of clk.
- Reset (reset=1 at a clock edge): spk=0, spkblty_out=1. Reset has priority over all other logic.
- Latency: outputs reflect potential/spkblty_in sampled at the previous rising edge (1 cycle). No combinational path from inputs to outputs.
- Comparisons are signed over WIDTH bits. No extension or saturation is required; parameters are sign-extended/truncated to WIDTH.
- Update rules per edge (P = potential):
  - spkblty_in=1, P >= V_HIGH: spk<=1, spkblty_out<=0 (fire and disarm).
  - spkblty_in=1, P < V_HIGH: spk<=0, spkblty_out<=1 (stay armed).
  - spkblty_in=0, P <= V_LOW: spk<=0, spkblty_out<=1 (re-arm, no spike in the same cycle).
  - spkblty_in=0, P > V_LOW: spk<=0, spkblty_out<=0 (stay refractory, even if P >= V_HIGH).
- spk is a single-cycle pulse per qualifying sample. If the caller keeps spkblty_in=1 while P stays >= V_HIGH, spk stays asserted every cycle. The block holds no arm state of its own besides its output registers.
- Boundaries:
  - P == V_HIGH fires.
  - P == V_LOW re-arms.
  - P = -128 always re-arms or stays armed without firing.
  - P = 127 fires when armed.
- spkblty_in X/unknown: implementation may propagate X; not a supported input.
- Reset mid-operation: outputs return to the reset values on that edge regardless of inputs. The next edge resumes normal rules.
- Elaboration check: V_LOW >= V_HIGH, or WIDTH < 2, is a fatal configuration error.

Decomposition:
- Shared package holds:
  - potential width constant (8);
  - default thresholds V_HIGH/V_LOW;
  - layer-select constants INPUT_LAYER=0, HIDDEN_LAYER=1, OUTPUT_LAYER=2, used by the surrounding spike processor.
- No sub-module required. Optionally factor the signed threshold compare into a small comparator, thresh_cmp; single-module implementation preferred.

Test Plan:
- Reset: assert reset 2 cycles with potential=100, spkblty_in=1 -> spk=0, spkblty_out=1 throughout. First edge after deassert -> spk=1, spkblty_out=0.
- Fire boundary, spkblty_in=1:
  - potential=63 -> next cycle spk=0, spkblty_out=1.
  - potential=64 -> spk=1, spkblty_out=0.
  - potential=127 -> spk=1, spkblty_out=0.
- Refractory hold, spkblty_in=0:
  - potential=100 -> spk=0, spkblty_out=0.
  - potential=1 -> spk=0, spkblty_out=0.
- Re-arm boundary, spkblty_in=0:
  - potential=0 -> spk=0, spkblty_out=1.
  - potential=-128 (0x80) -> spk=0, spkblty_out=1.
- Closed-loop hysteresis: feed spkblty_out back to spkblty_in; ramp potential 0,32,64,96,64,32,0,64 -> spk sequence 0,0,1,0,0,0,0,1 (one-cycle lag), spkblty_out re-arms on the sample with potential 0.
- Signedness: potential=0xC0 (-64), spkblty_in=1 -> spk=0, spkblty_out=1. Confirms no unsigned compare (unsigned 192 would wrongly fire).
